// File: rtl/gate_bist_2in.sv
// rtl/gate_bist_2in.sv - built-in self-test engine for a 2-input logic gate
//
// Purpose: steps gate inputs {a,b} through 00,01,10,11, holds each vector for
// SETTLE_CYCLES, samples gate_y for one cycle, and compares it against
// EXPECTED_TT[{a,b}]. It reports a per-vector fail mask, a mismatch count and
// a pass flag.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   synchronous active-high reset
//   start      in   begin a run (sampled only in IDLE)
//   gate_y     in   output of the gate under test
//   gate_a     out  drive to gate input a
//   gate_b     out  drive to gate input b
//   busy       out  run in progress (APPLY/CHECK)
//   done       out  one-cycle pulse when a run completes
//   pass       out  last completed run had no mismatches
//   err_count  out  mismatching vectors in last run (0..4)
//   fail_mask  out  bit v set if vector v mismatched in last run
module gate_bist_2in #(
  parameter int unsigned SETTLE_CYCLES = 2,
  parameter logic [3:0]  EXPECTED_TT   = 4'b0001
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       start,
  input  logic       gate_y,
  output logic       gate_a,
  output logic       gate_b,
  output logic       busy,
  output logic       done,
  output logic       pass,
  output logic [2:0] err_count,
  output logic [3:0] fail_mask
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_APPLY  = 2'd1,
    S_CHECK  = 2'd2,
    S_FINISH = 2'd3
  } state_t;

  localparam logic [3:0] LP_RELOAD = 4'(SETTLE_CYCLES - 1);

  state_t     r_state;
  state_t     w_next_state;

  logic [1:0] r_vec;
  logic [3:0] r_cnt;
  logic [3:0] r_mask;
  logic [2:0] r_errs;

  logic [1:0] w_vec_next;
  logic [3:0] w_cnt_next;
  logic [3:0] w_mask_next;
  logic [2:0] w_errs_next;
  logic       w_busy_next;
  logic       w_done_next;
  logic [1:0] w_ab_next;
  logic       w_load_results;
  logic       w_mismatch;

  // Four-state inequality: an X or Z on gate_y is a mismatch, never a match.
  assign w_mismatch = (gate_y !== EXPECTED_TT[r_vec]);

  // State register
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      S_IDLE:   if (start) w_next_state = S_APPLY;
      S_APPLY:  if (r_cnt == 4'd0) w_next_state = S_CHECK;
      S_CHECK:  w_next_state = (r_vec == 2'd3) ? S_FINISH : S_APPLY;
      S_FINISH: w_next_state = S_IDLE;
      default:  w_next_state = S_IDLE;
    endcase
  end

  // Output / datapath logic. Outputs are computed from the next state and
  // registered below, so every port is a flop aligned with the state register.
  always_comb begin
    w_vec_next  = r_vec;
    w_cnt_next  = r_cnt;
    w_mask_next = r_mask;
    w_errs_next = r_errs;
    case (r_state)
      S_IDLE: begin
        if (start) begin
          w_vec_next  = 2'd0;
          w_cnt_next  = LP_RELOAD;
          w_mask_next = 4'd0;
          w_errs_next = 3'd0;
        end
      end
      S_APPLY: begin
        if (r_cnt != 4'd0) w_cnt_next = r_cnt - 4'd1;
      end
      S_CHECK: begin
        if (w_mismatch) begin
          w_mask_next = r_mask | (4'b0001 << r_vec);
          w_errs_next = r_errs + 3'd1;
        end
        if (r_vec != 2'd3) begin
          w_vec_next = r_vec + 2'd1;
          w_cnt_next = LP_RELOAD;
        end
      end
      S_FINISH: begin
        w_vec_next = 2'd0;
      end
      default: begin
        w_vec_next = 2'd0;
      end
    endcase

    w_busy_next    = (w_next_state == S_APPLY) || (w_next_state == S_CHECK);
    w_done_next    = (w_next_state == S_FINISH);
    w_ab_next      = w_busy_next ? w_vec_next : 2'b00;
    // Results are published on entry to FINISH, including the last vector's
    // compare from this same CHECK cycle.
    w_load_results = (r_state == S_CHECK) && (w_next_state == S_FINISH);
  end

  // Datapath and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      r_vec     <= 2'd0;
      r_cnt     <= 4'd0;
      r_mask    <= 4'd0;
      r_errs    <= 3'd0;
      gate_a    <= 1'b0;
      gate_b    <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= 3'd0;
      fail_mask <= 4'd0;
    end else begin
      r_vec  <= w_vec_next;
      r_cnt  <= w_cnt_next;
      r_mask <= w_mask_next;
      r_errs <= w_errs_next;
      gate_a <= w_ab_next[1];
      gate_b <= w_ab_next[0];
      busy   <= w_busy_next;
      done   <= w_done_next;
      if (w_load_results) begin
        fail_mask <= w_mask_next;
        err_count <= w_errs_next;
        pass      <= (w_errs_next == 3'd0);
      end
    end
  end

endmodule
